multi_timer: RTL and testbench

- Parametrised multi-channel memory-mapped timer/counter; successor to the single-channel 3-register timer used on the CPU's bridge.
- NCH independent channels with configurable counter width.
- Each channel supports one-shot and auto-reload modes, a sticky write-1-to-clear pending flag, and a per-channel interrupt mask.
- Sits behind the system bridge; per-channel IRQs and an OR-combined IRQ feed the CP0 interrupt inputs.

---
 rtl/timer_pkg.sv | 27 ++
 rtl/timer_channel.sv | 135 +++++++++++++
 rtl/multi_timer.sv | 54 +++++
 tb/tb_multi_timer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Purpose: shared encodings for multi_timer (FSM states, register offsets, CTRL fields).
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional prescaler fields are used only when TIMER_PRESCALE_EN is defined.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_MODE = 1;
    localparam int CTRL_IM   = 3;
    localparam int CTRL_PSC  = 4;
    localparam int PSC_W     = 8;

endpackage

// File: rtl/timer_channel.sv
// Purpose: one timer channel - CTRL/PRESET/COUNT/STATUS registers, IDLE/LOAD/CNT/INT FSM, optional prescaler (TIMER_PRESCALE_EN).
// Latency: register writes land on the write edge; dout is combinational from registered state.
// Backpressure: none; a CTRL/PRESET/COUNT write freezes this channel's FSM for that cycle, STATUS writes do not.
module timer_channel
    import timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [1:0]  reg_sel,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    state_t             state;
    logic               en;
    logic               im;
    logic               pend;
    logic [1:0]         mode;
    logic [CNT_W-1:0]   preset;
    logic [CNT_W-1:0]   count;
    logic               tick;
    logic               fsm_hold;
    logic               unused_din;

`ifdef TIMER_PRESCALE_EN
    logic [PSC_W-1:0]   psc;
    logic [PSC_W-1:0]   pcnt;
    assign tick = (pcnt == psc);
`else
    assign tick = 1'b1;
`endif

    // STATUS only touches PEND, so it never stalls counting; any other write owns the cycle
    assign fsm_hold   = we && (reg_sel != REG_STATUS);
    assign unused_din = ^din;
    assign irq        = pend & im;

    // Register writes and the channel FSM; PEND set is placed after the W1C so set wins
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            en     <= 1'b0;
            im     <= 1'b0;
            pend   <= 1'b0;
            mode   <= MODE_ONESHOT;
            preset <= '0;
            count  <= '0;
`ifdef TIMER_PRESCALE_EN
            psc    <= '0;
            pcnt   <= '0;
`endif
        end else begin
            if (we) begin
                case (reg_sel)
                    REG_CTRL: begin
                        en   <= din[CTRL_EN];
                        mode <= din[CTRL_MODE +: 2];
                        im   <= din[CTRL_IM];
`ifdef TIMER_PRESCALE_EN
                        psc  <= din[CTRL_PSC +: PSC_W];
`endif
                    end
                    REG_PRESET: preset <= din[CNT_W-1:0];
                    REG_COUNT:  count  <= din[CNT_W-1:0];
                    REG_STATUS: if (din[0]) pend <= 1'b0;
                endcase
            end
            if (!fsm_hold) begin
                case (state)
                    IDLE: if (en) state <= LOAD;
                    LOAD: begin
                        count <= preset;
`ifdef TIMER_PRESCALE_EN
                        pcnt  <= '0;
`endif
                        state <= CNT;
                    end
                    CNT: begin
                        if (!en) begin
                            state <= IDLE;
                        end else if (tick) begin
`ifdef TIMER_PRESCALE_EN
                            pcnt <= '0;
`endif
                            if (count > CNT_W'(1)) begin
                                count <= count - CNT_W'(1);
                            end else begin
                                count <= '0;
                                pend  <= 1'b1;
                                state <= INT;
                            end
                        end
`ifdef TIMER_PRESCALE_EN
                        else begin
                            pcnt <= pcnt + PSC_W'(1);
                        end
`endif
                    end
                    INT: begin
                        if (mode == MODE_RELOAD) begin
                            state <= LOAD;
                        end else begin
                            en    <= 1'b0;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Read mux; unimplemented bits read as zero
    always_comb begin
        dout = '0;
        case (reg_sel)
            REG_CTRL: begin
                dout[CTRL_EN]         = en;
                dout[CTRL_MODE +: 2]  = mode;
                dout[CTRL_IM]         = im;
`ifdef TIMER_PRESCALE_EN
                dout[CTRL_PSC +: PSC_W] = psc;
`endif
            end
            REG_PRESET: dout = 32'(preset);
            REG_COUNT:  dout = 32'(count);
            REG_STATUS: dout[0] = pend;
        endcase
    end

endmodule

// File: rtl/multi_timer.sv
// Purpose: NCH-channel memory-mapped timer - address decode, read mux, IRQ fan-in (prescaler under TIMER_PRESCALE_EN).
// Latency: writes take effect on the write edge; Dout, IRQ and IRQ_any are combinational from registers.
// Backpressure: none; every bus access completes in one cycle, out-of-range channels read 0 and drop writes.
module multi_timer
    import timer_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:2]     Addr,
    input  logic            WE,
    input  logic [31:0]     Din,
    output logic [31:0]     Dout,
    output logic [NCH-1:0]  IRQ,
    output logic            IRQ_any
);

    localparam int CHB = (NCH > 1) ? $clog2(NCH) : 1;

    logic [CHB-1:0] chan;
    logic           in_range;
    logic [31:0]    rd_dat [NCH];

    // The whole field above the register offset is the channel index, so aliases of
    // non-existent channels are rejected instead of wrapping onto real ones
    assign chan     = Addr[4 +: CHB];
    assign in_range = (Addr[31:4] < 28'(NCH));
    assign IRQ_any  = |IRQ;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        timer_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .we      (WE && in_range && (chan == CHB'(i))),
            .reg_sel (Addr[3:2]),
            .din     (Din),
            .dout    (rd_dat[i]),
            .irq     (IRQ[i])
        );
    end

    // Read data select; zero when the channel does not exist
    always_comb begin
        Dout = '0;
        for (int i = 0; i < NCH; i++) begin
            if (in_range && (chan == CHB'(i))) Dout = rd_dat[i];
        end
    end

endmodule

// File: tb/tb_multi_timer.sv
// Purpose: directed self-checking bench for multi_timer (NCH=2, CNT_W=32), with or without TIMER_PRESCALE_EN.
// Latency: inputs driven 1ns after the rising edge, outputs sampled before the next edge.
// Backpressure: n/a.
module tb_multi_timer;
    import timer_pkg::*;

    localparam int NCH = 2;

    logic        clk;
    logic        reset;
    logic [31:2] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic [NCH-1:0] IRQ;
    logic        IRQ_any;

    int n_pass = 0;
    int n_tot  = 0;

    multi_timer #(.NCH(NCH), .CNT_W(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .Addr    (Addr),
        .WE      (WE),
        .Din     (Din),
        .Dout    (Dout),
        .IRQ     (IRQ),
        .IRQ_any (IRQ_any)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          ch;
        int          r;
        bit          we;
        logic [31:0] din;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int r, input logic [31:0] d);
        Addr = 30'(ch * 4 + r);
        Din  = d;
        WE   = 1'b1;
        @(posedge clk);
        #1;
        WE   = 1'b0;
    endtask

    task automatic rd(input int ch, input int r, output logic [31:0] d);
        WE   = 1'b0;
        Addr = 30'(ch * 4 + r);
        #1;
        d = Dout;
    endtask

    // Step until IRQ[ch] is seen or the budget runs out; returns cycles waited
    task automatic wait_irq(input int ch, input int limit, output int waited);
        waited = 0;
        while (!IRQ[ch] && waited < limit) begin
            step(1);
            waited++;
        end
    endtask

    logic [31:0] d;
    int          w;
    logic [31:0] ctrl_mask_rb;
    logic [31:0] psc_ctrl_rb;
    int          psc_expiry;

    initial begin
`ifdef TIMER_PRESCALE_EN
        ctrl_mask_rb = 32'h0000_0FF6;
        psc_ctrl_rb  = 32'h0000_0038;
        psc_expiry   = 2 + 4 * 4;
`else
        ctrl_mask_rb = 32'h0000_0006;
        psc_ctrl_rb  = 32'h0000_0008;
        psc_expiry   = 2 + 4;
`endif
        for (int c = 0; c < NCH; c++)
            for (int r = 0; r < 4; r++)
                vecs.push_back('{c, r, 1'b0, 32'h0, 32'h0, "reset read"});
        vecs.push_back('{0, 1, 1'b1, 32'h1234_5678, 32'h1234_5678, "ch0 preset rw"});
        vecs.push_back('{1, 2, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "ch1 count rw"});
        vecs.push_back('{1, 0, 1'b1, 32'hFFFF_FFF6, ctrl_mask_rb,  "ch1 ctrl field mask"});
        vecs.push_back('{1, 3, 1'b1, 32'hFFFF_FFFF, 32'h0,         "ch1 status w1c idle"});
        vecs.push_back('{2, 1, 1'b1, 32'hAAAA_AAAA, 32'h0,         "oob ch2 write/read"});
        vecs.push_back('{3, 1, 1'b1, 32'h5555_5555, 32'h0,         "oob ch3 write/read"});
        vecs.push_back('{0, 1, 1'b0, 32'h0,         32'h1234_5678, "ch0 preset after oob"});
        vecs.push_back('{1, 1, 1'b0, 32'h0,         32'h0,         "ch1 preset after oob"});

        reset = 1'b1;
        WE    = 1'b0;
        Addr  = '0;
        Din   = '0;
        step(3);
        reset = 1'b0;

        chk("reset IRQ", 32'(IRQ), 32'h0);
        chk("reset IRQ_any", 32'(IRQ_any), 32'h0);

        foreach (vecs[i]) begin
            if (vecs[i].we) wr(vecs[i].ch, vecs[i].r, vecs[i].din);
            rd(vecs[i].ch, vecs[i].r, d);
            chk(vecs[i].name, d, vecs[i].exp);
        end
        wr(0, REG_PRESET, 32'h0);
        wr(1, REG_COUNT,  32'h0);
        wr(1, REG_CTRL,   32'h0);

        // One-shot ch0, PRESET=5: IDLE sees EN the cycle after the write, LOAD copies
        // PRESET, then 5 counting cycles -> PEND on the 7th edge after the CTRL write
        wr(0, REG_PRESET, 32'd5);
        wr(0, REG_CTRL,   32'h9);
        step(2);
        rd(0, REG_COUNT, d);   chk("ch0 count after load", d, 32'd5);
        step(4);
        rd(0, REG_COUNT, d);   chk("ch0 count last tick", d, 32'd1);
        chk("ch0 irq before expiry", 32'(IRQ[0]), 32'h0);
        step(1);
        chk("ch0 irq at expiry", 32'(IRQ[0]), 32'h1);
        chk("irq_any at expiry", 32'(IRQ_any), 32'h1);
        rd(0, REG_COUNT, d);   chk("ch0 count expired", d, 32'd0);
        step(1);
        rd(0, REG_CTRL, d);    chk("ch0 ctrl en cleared", d, 32'h8);
        rd(0, REG_STATUS, d);  chk("ch0 pend read", d, 32'h1);
        wr(0, REG_STATUS, 32'h1);
        chk("ch0 irq after w1c", 32'(IRQ[0]), 32'h0);
        chk("irq_any after w1c", 32'(IRQ_any), 32'h0);

        // Auto-reload ch1, PRESET=3: first expiry 5 edges after the write, then period 5
        wr(1, REG_PRESET, 32'd3);
        wr(1, REG_CTRL,   32'hB);
        wait_irq(1, 20, w);
        chk("ch1 first expiry", 32'(w), 32'd5);
        wr(1, REG_STATUS, 32'h1);                       // E+1
        chk("ch1 w1c clears", 32'(IRQ[1]), 32'h0);
        step(3);                                        // E+4
        chk("ch1 before 2nd expiry", 32'(IRQ[1]), 32'h0);
        step(1);                                        // E+5
        chk("ch1 2nd expiry", 32'(IRQ[1]), 32'h1);
        rd(1, REG_CTRL, d);    chk("ch1 ctrl en kept", d, 32'hB);

        // Bus traffic to ch0 on ch1's expiry edge must not disturb ch1
        wr(1, REG_STATUS, 32'h1);                       // E+6
        wr(0, REG_PRESET, 32'd2);                       // E+7
        step(2);                                        // E+9
        chk("ch1 before 3rd expiry", 32'(IRQ[1]), 32'h0);
        wr(0, REG_COUNT, 32'h77);                       // E+10
        chk("ch1 3rd expiry on time", 32'(IRQ[1]), 32'h1);
        rd(0, REG_COUNT, d);   chk("ch0 count write", d, 32'h77);
        wr(1, REG_STATUS, 32'h1);                       // E+11
        chk("ch1 cleared again", 32'(IRQ[1]), 32'h0);
        step(3);                                        // E+14
        wr(1, REG_STATUS, 32'h1);                       // E+15, coincides with expiry
        chk("ch1 set wins over w1c", 32'(IRQ[1]), 32'h1);
        wr(1, REG_STATUS, 32'h1);                       // E+16
        step(3);                                        // E+19
        chk("ch1 quiet after set-wins", 32'(IRQ[1]), 32'h0);
        step(1);                                        // E+20
        chk("ch1 5th expiry on time", 32'(IRQ[1]), 32'h1);
        wr(1, REG_CTRL, 32'h0);
        step(5);
        wr(1, REG_STATUS, 32'h1);

        // Disable mid-count holds COUNT; re-enable reloads from PRESET
        wr(0, REG_PRESET, 32'd100);
        wr(0, REG_CTRL,   32'h1);
        step(62);
        rd(0, REG_COUNT, d);   chk("ch0 count at 40", d, 32'd40);
        wr(0, REG_CTRL, 32'h0);
        step(3);
        rd(0, REG_COUNT, d);   chk("ch0 count held", d, 32'd40);
        rd(0, REG_STATUS, d);  chk("ch0 no pend on disable", d, 32'h0);
        chk("irq_any idle", 32'(IRQ_any), 32'h0);
        wr(0, REG_CTRL, 32'h1);
        step(1);
        rd(0, REG_COUNT, d);   chk("ch0 count during load", d, 32'd40);
        step(1);
        rd(0, REG_COUNT, d);   chk("ch0 reloaded", d, 32'd100);
        wr(0, REG_CTRL, 32'h0);
        step(3);

        // Prescaler: PSC=3, PRESET=4 -> one decrement every 4 counting cycles
        wr(0, REG_STATUS, 32'h1);
        wr(0, REG_PRESET, 32'd4);
        wr(0, REG_CTRL,   32'h39);
        wait_irq(0, 40, w);
        chk("psc3 expiry", 32'(w), 32'(psc_expiry));
        step(1);
        rd(0, REG_CTRL, d);    chk("psc ctrl readback", d, psc_ctrl_rb);
        wr(0, REG_STATUS, 32'h1);
        wr(0, REG_CTRL,   32'h9);
        wait_irq(0, 40, w);
        chk("psc0 expiry", 32'(w), 32'd6);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
